// File: rtl/dlfloat16_cmp_issue_if.sv
// Request/response channels between a requester and the DLfloat16 compare issue sequencer.
// Requester is the master; the sequencer is the slave.
interface dlfloat16_cmp_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_tag;
   logic [4:0]  out_exc;

   modport master (
      output in_valid, in_op, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_exc
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_exc
   );
endinterface

// File: rtl/dlfloat16_cmp_issue.sv
// Issues one DLfloat16 compare at a time to a registered comparator; response valid 3 cycles after the request is presented.
// out_ready low holds the response stable and keeps in_ready low, so nothing new is accepted.
module dlfloat16_cmp_issue (
   input  logic                        clk,
   input  logic                        rst_n,
   dlfloat16_cmp_issue_if.slave        bus,
   output logic [15:0]                 cmp_a1,
   output logic [15:0]                 cmp_b1,
   output logic [2:0]                  cmp_sel,
   output logic [3:0]                  cmp_ena,
   input  logic [31:0]                 cmp_c_out,
   input  logic [4:0]                  cmp_exc,
   output logic [4:0]                  sticky_exc,
   input  logic                        flags_clr,
   output logic                        err_illegal,
   output logic [15:0]                 resp_count
);
   localparam logic [3:0] ENA_CMP     = 4'b0110;
   localparam logic [4:0] EXC_INVALID = 5'b10000;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  tag;
   } req_t;

   state_t state;
   req_t   hold;
   logic   cmp_on;
   logic   accept;
   logic   legal_op;
   logic   resp_hs;
   logic   unused_cmp_hi;

   assign accept        = bus.in_valid && bus.in_ready;
   assign legal_op      = bus.in_op inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
   assign resp_hs       = bus.out_valid && bus.out_ready;
   assign unused_cmp_hi = ^cmp_c_out[31:16];

   // Comparator drive is the holding register qualified by a registered enable, zero otherwise.
   assign cmp_ena = cmp_on ? ENA_CMP : 4'b0000;
   assign cmp_sel = cmp_on ? hold.op : 3'b000;
   assign cmp_a1  = cmp_on ? hold.a  : 16'h0000;
   assign cmp_b1  = cmp_on ? hold.b  : 16'h0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         hold           <= '0;
         cmp_on         <= 1'b0;
         bus.in_ready   <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_result <= 16'h0000;
         bus.out_tag    <= 4'h0;
         bus.out_exc    <= 5'b00000;
         sticky_exc     <= 5'b00000;
         resp_count     <= 16'h0000;
         err_illegal    <= 1'b0;
      end else begin
         err_illegal <= 1'b0;

         // A clear coinciding with a handshake keeps only the new response's flags.
         if (flags_clr)
            sticky_exc <= resp_hs ? bus.out_exc : 5'b00000;
         else if (resp_hs)
            sticky_exc <= sticky_exc | bus.out_exc;

         case (state)
            IDLE: begin
               if (accept) begin
                  hold         <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b, tag: bus.in_tag};
                  bus.in_ready <= 1'b0;
                  if (legal_op) begin
                     cmp_on <= 1'b1;
                     state  <= ISSUE;
                  end else begin
                     bus.out_valid  <= 1'b1;
                     bus.out_result <= 16'h0000;
                     bus.out_exc    <= EXC_INVALID;
                     bus.out_tag    <= bus.in_tag;
                     err_illegal    <= 1'b1;
                     state          <= RESP;
                  end
               end else begin
                  bus.in_ready <= 1'b1;
               end
            end
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               bus.out_result <= cmp_c_out[15:0];
               bus.out_exc    <= cmp_exc;
               bus.out_tag    <= hold.tag;
               bus.out_valid  <= 1'b1;
               cmp_on         <= 1'b0;
               state          <= RESP;
            end
            RESP: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  resp_count    <= resp_count + 16'd1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
